// File: rtl/mr_pkg.sv
// Shared state types, prime base table and helpers for the Miller-Rabin engine
// and its modular multiplier.
package mr_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DECOMP,
    ST_ROUND_INIT,
    ST_EXP_SQ,
    ST_EXP_MUL,
    ST_EVAL,
    ST_SQ_LOOP,
    ST_DONE
  } mr_state_t;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_RUN,
    MM_OUT
  } mm_phase_t;

  localparam int MR_NUM_BASES = 12;
  localparam int unsigned MR_BASES [MR_NUM_BASES] =
    '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37};

  function automatic int unsigned clamp_rounds(input int unsigned req,
                                               input int unsigned max_rounds);
    return (req > max_rounds) ? max_rounds : req;
  endfunction

  // Table lookup by comparison so callers may pass an index of any width.
  function automatic int unsigned mr_base(input int unsigned idx);
    int unsigned b;
    b = 0;
    for (int i = 0; i < MR_NUM_BASES; i++) begin
      if (idx == 32'(i)) b = MR_BASES[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/mr_modmul.sv
// Interleaved shift-add modular multiplier: p = a*b mod m, one bit of a per cycle.
// A start while busy restarts the operation; done pulses WIDTH+2 cycles after start.
module mr_modmul
  import mr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mm_phase_t        phase;
  logic [WIDTH-1:0] a_r, b_r, m_r, acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] m_x, dbl, dbl_red, sum, sum_red;
  logic [1:0]       unused_hi;

  // acc < m, so 2*acc and (2*acc mod m) + b both stay below 2m and need one subtract each.
  // NOTE: every variable written here is assigned on every path, so no latch can form.
  always_comb begin
    m_x     = {2'b00, m_r};
    dbl     = {1'b0, acc, 1'b0};
    dbl_red = (dbl >= m_x) ? dbl - m_x : dbl;
    sum     = dbl_red + (a_r[WIDTH-1] ? {2'b00, b_r} : '0);
    sum_red = (sum >= m_x) ? sum - m_x : sum;
  end

  assign unused_hi = sum_red[WIDTH+1:WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= MM_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      m_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      p     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_r   <= a;
        b_r   <= b;
        m_r   <= m;
        acc   <= '0;
        cnt   <= CW'(WIDTH - 1);
        phase <= MM_RUN;
      end else begin
        case (phase)
          MM_RUN: begin
            acc <= sum_red[WIDTH-1:0];
            a_r <= a_r << 1;
            if (cnt == '0) phase <= MM_OUT;
            else           cnt   <= cnt - 1'b1;
          end
          MM_OUT: begin
            p     <= acc;
            done  <= 1'b1;
            phase <= MM_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/miller_rabin_engine.sv
// Miller-Rabin primality tester with fixed prime bases and a shared sequential multiplier.
// Optional MR_ABORT_EN adds an abort input that cancels a running test without a done pulse.
module miller_rabin_engine
  import mr_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_ROUNDS = 8,
  parameter int ROUND_W    = $clog2(MAX_ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   n,
  input  logic [ROUND_W-1:0] rounds,
`ifdef MR_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic               is_prime,
  output logic [WIDTH-1:0]   witness,
  output logic [ROUND_W-1:0] rounds_run
);

  localparam int SW = $clog2(WIDTH) + 1;
  localparam int PW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mr_state_t          state;
  logic [WIDTH-1:0]   n_r, nm1_r, d_r, y_r, base_r;
  logic [SW-1:0]      s_r, j_r;
  logic [PW-1:0]      bit_ptr;
  logic [ROUND_W-1:0] rounds_eff, round_idx;

  logic [WIDTH-1:0]   cur_base;
  logic               rounds_left, skip_base, y_pass, abort_hit;

  logic               mm_start, mm_done;
  logic [WIDTH-1:0]   mm_a, mm_b, mm_p;

`ifdef MR_ABORT_EN
  assign abort_hit = abort && busy;
`else
  assign abort_hit = 1'b0;
`endif

  assign cur_base    = WIDTH'(mr_base(32'(round_idx)));
  assign rounds_left = (round_idx != rounds_eff);
  assign skip_base   = (cur_base >= nm1_r);
  assign y_pass      = (y_r == ONE) || (y_r == nm1_r);

  // Multiplies are issued combinationally from the previous product so they run back to back.
  always_comb begin
    mm_start = 1'b0;
    mm_a     = y_r;
    mm_b     = y_r;
    case (state)
      ST_ROUND_INIT:
        if (rounds_left && !skip_base) begin
          mm_start = 1'b1;
          mm_a     = ONE;
          mm_b     = ONE;
        end
      ST_EXP_SQ:
        if (mm_done) begin
          if (d_r[bit_ptr]) begin
            mm_start = 1'b1;
            mm_a     = mm_p;
            mm_b     = base_r;
          end else if (bit_ptr != '0) begin
            mm_start = 1'b1;
            mm_a     = mm_p;
            mm_b     = mm_p;
          end
        end
      ST_EXP_MUL:
        if (mm_done && bit_ptr != '0) begin
          mm_start = 1'b1;
          mm_a     = mm_p;
          mm_b     = mm_p;
        end
      ST_EVAL:
        mm_start = !y_pass && (s_r > SW'(1));
      ST_SQ_LOOP:
        if (mm_done && mm_p != nm1_r && mm_p != ONE && (j_r + SW'(1)) < s_r) begin
          mm_start = 1'b1;
          mm_a     = mm_p;
          mm_b     = mm_p;
        end
      default: ;
    endcase
    if (abort_hit) mm_start = 1'b0;
  end

  mr_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk   (clk),
    .rst   (rst),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .m     (n_r),
    .done  (mm_done),
    .p     (mm_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      is_prime   <= 1'b0;
      witness    <= '0;
      rounds_run <= '0;
      n_r        <= '0;
      nm1_r      <= '0;
      d_r        <= '0;
      y_r        <= '0;
      base_r     <= '0;
      s_r        <= '0;
      j_r        <= '0;
      bit_ptr    <= '0;
      rounds_eff <= '0;
      round_idx  <= '0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              n_r        <= n;
              rounds_eff <= ROUND_W'(clamp_rounds(32'(rounds), 32'(MAX_ROUNDS)));
              busy       <= 1'b1;
              state      <= ST_CHECK;
            end else begin
              state <= ST_IDLE;
            end
          end

          ST_CHECK: begin
            nm1_r     <= n_r - ONE;
            d_r       <= n_r - ONE;
            s_r       <= '0;
            round_idx <= '0;
            if (n_r < WIDTH'(4) || !n_r[0]) begin
              // 2 and 3 are prime; 0, 1 and every other even value are composite.
              is_prime   <= (n_r == WIDTH'(2)) || (n_r == WIDTH'(3));
              witness    <= '0;
              rounds_run <= '0;
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_DONE;
            end else begin
              state <= ST_DECOMP;
            end
          end

          ST_DECOMP: begin
            if (!d_r[0]) begin
              d_r <= d_r >> 1;
              s_r <= s_r + 1'b1;
            end else begin
              state <= ST_ROUND_INIT;
            end
          end

          ST_ROUND_INIT: begin
            if (!rounds_left) begin
              is_prime   <= 1'b1;
              witness    <= '0;
              rounds_run <= rounds_eff;
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_DONE;
            end else if (skip_base) begin
              round_idx <= round_idx + 1'b1;
            end else begin
              base_r  <= cur_base;
              y_r     <= ONE;
              bit_ptr <= PW'(WIDTH - 1);
              state   <= ST_EXP_SQ;
            end
          end

          ST_EXP_SQ: begin
            if (mm_done) begin
              y_r <= mm_p;
              if (d_r[bit_ptr])         state   <= ST_EXP_MUL;
              else if (bit_ptr == '0)   state   <= ST_EVAL;
              else                      bit_ptr <= bit_ptr - 1'b1;
            end
          end

          ST_EXP_MUL: begin
            if (mm_done) begin
              y_r <= mm_p;
              if (bit_ptr == '0) begin
                state <= ST_EVAL;
              end else begin
                bit_ptr <= bit_ptr - 1'b1;
                state   <= ST_EXP_SQ;
              end
            end
          end

          ST_EVAL: begin
            if (y_pass) begin
              round_idx <= round_idx + 1'b1;
              state     <= ST_ROUND_INIT;
            end else if (s_r > SW'(1)) begin
              j_r   <= SW'(1);
              state <= ST_SQ_LOOP;
            end else begin
              is_prime   <= 1'b0;
              witness    <= base_r;
              rounds_run <= round_idx + 1'b1;
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_DONE;
            end
          end

          ST_SQ_LOOP: begin
            if (mm_done) begin
              y_r <= mm_p;
              if (mm_p == nm1_r) begin
                round_idx <= round_idx + 1'b1;
                state     <= ST_ROUND_INIT;
              end else if (mm_p == ONE || (j_r + SW'(1)) >= s_r) begin
                // A nontrivial square root of 1, or the squarings ran out before reaching n-1.
                is_prime   <= 1'b0;
                witness    <= base_r;
                rounds_run <= round_idx + 1'b1;
                done       <= 1'b1;
                busy       <= 1'b0;
                state      <= ST_DONE;
              end else begin
                j_r <= j_r + 1'b1;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_miller_rabin_engine.sv
// Directed bench for miller_rabin_engine: vector table plus start-ignore, reset and abort sequences.
module tb_miller_rabin_engine;

  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] n;
  logic [3:0]  rounds;
`ifdef MR_ABORT_EN
  logic        abort;
`endif
  logic        busy, done, is_prime;
  logic [31:0] witness;
  logic [3:0]  rounds_run;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  miller_rabin_engine #(.WIDTH(32), .MAX_ROUNDS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n          (n),
    .rounds     (rounds),
`ifdef MR_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .is_prime   (is_prime),
    .witness    (witness),
    .rounds_run (rounds_run)
  );

  typedef struct {
    logic [31:0] n;
    logic [3:0]  rounds;
    logic        prime;
    logic [31:0] wit;
    logic [3:0]  rr;
    int          lat;   // expected done cycle after start, 0 = not checked
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits on negedges until done is seen or the budget expires.
  task automatic wait_done(input int limit, inout int cyc, output bit seen);
    seen = 1'b0;
    while (!seen && cyc < limit) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic pulse_start(input logic [31:0] nv, input logic [3:0] rv);
    @(negedge clk);
    n      = nv;
    rounds = rv;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    bit seen;
    pulse_start(v.n, v.rounds);
    cyc = 1;
    check($sformatf("v%0d_busy_after_start", idx), busy, 1);
    wait_done(LIMIT, cyc, seen);
    check($sformatf("v%0d_done_seen", idx), seen, 1);
    if (seen) begin
      if (v.lat != 0) check($sformatf("v%0d_latency", idx), cyc, v.lat);
      check($sformatf("v%0d_is_prime", idx), is_prime, v.prime);
      check($sformatf("v%0d_witness", idx), witness, v.wit);
      check($sformatf("v%0d_rounds_run", idx), rounds_run, v.rr);
      check($sformatf("v%0d_busy_at_done", idx), busy, 0);
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", idx), done, 0);
    end
  endtask

  initial begin
    int  cyc;
    bit  seen;
    bit  got_done;

    vecs[0]  = '{32'd0,          4'd8,  1'b0, 32'd0,  4'd0, 2};
    vecs[1]  = '{32'd1,          4'd8,  1'b0, 32'd0,  4'd0, 2};
    vecs[2]  = '{32'd2,          4'd8,  1'b1, 32'd0,  4'd0, 2};
    vecs[3]  = '{32'd3,          4'd8,  1'b1, 32'd0,  4'd0, 2};
    vecs[4]  = '{32'd4,          4'd8,  1'b0, 32'd0,  4'd0, 2};
    vecs[5]  = '{32'd561,        4'd8,  1'b0, 32'd2,  4'd1, 0};
    vecs[6]  = '{32'd2047,       4'd1,  1'b1, 32'd0,  4'd1, 0};
    vecs[7]  = '{32'd2047,       4'd2,  1'b0, 32'd3,  4'd2, 0};
    vecs[8]  = '{32'd3215031751, 4'd4,  1'b1, 32'd0,  4'd4, 0};
    vecs[9]  = '{32'd3215031751, 4'd5,  1'b0, 32'd11, 4'd5, 0};
    vecs[10] = '{32'd7,          4'd8,  1'b1, 32'd0,  4'd8, 0};
    vecs[11] = '{32'd7,          4'd15, 1'b1, 32'd0,  4'd8, 0};
    vecs[12] = '{32'd13,         4'd8,  1'b1, 32'd0,  4'd8, 0};
    vecs[13] = '{32'd9,          4'd8,  1'b0, 32'd2,  4'd1, 0};
    vecs[14] = '{32'd15,         4'd8,  1'b0, 32'd2,  4'd1, 0};
    vecs[15] = '{32'd9,          4'd0,  1'b1, 32'd0,  4'd0, 0};

    rst    = 1'b1;
    start  = 1'b0;
    n      = '0;
    rounds = '0;
`ifdef MR_ABORT_EN
    abort  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_is_prime", is_prime, 0);
    check("reset_witness", witness, 0);
    check("reset_rounds_run", rounds_run, 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // 65537 with a second start (n=15) pulsed mid-run; the second start must be dropped.
    pulse_start(32'd65537, 4'd8);
    cyc = 1;
    repeat (99) begin
      @(negedge clk);
      cyc++;
    end
    n     = 32'd15;
    rounds = 4'd1;
    start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    wait_done(LIMIT, cyc, seen);
    check("f4_done_seen", seen, 1);
    check("f4_is_prime", is_prime, 1);
    check("f4_witness", witness, 0);
    check("f4_rounds_run", rounds_run, 8);

    // Reset in the middle of a test of 13: busy drops at once, no done follows.
    pulse_start(32'd13, 4'd8);
    repeat (50) @(negedge clk);
    check("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy_cleared", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    got_done = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    check("rst_mid_no_done", got_done, 0);
    check("rst_mid_is_prime", is_prime, 0);
    check("rst_mid_busy_idle", busy, 0);

`ifdef MR_ABORT_EN
    // Establish a known result, then abort 65537 while it sits in the squaring loop of base 2.
    run_vec(vecs[14], 100);
    pulse_start(32'd65537, 4'd8);
    repeat (1199) @(negedge clk);
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_next", busy, 0);
    check("abort_no_done_now", done, 0);
    got_done = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    check("abort_no_done_later", got_done, 0);
    check("abort_is_prime_kept", is_prime, 0);
    check("abort_witness_kept", witness, 2);
    check("abort_rounds_run_kept", rounds_run, 1);
    run_vec(vecs[7], 101);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
